movement_executor: RTL
======================

# movement_executor

Downstream stage of the search FSM: consumes its 4-bit `movement_sel` and turns each command into a timed, bounded motor action on the two-wheel drive, with a brake/settle gap between actions. Filters glitches on the combinational `movement_sel` bus, executes exactly one command at a time, and reports completion, abort and illegal-code events. Also provides an emergency-stop path.

## Interface
- `FWD_CYCLES`, default 50000: drive duration for forward/reverse moves, in clk cycles (≥1).
- `TURN_CYCLES`, default 25000: drive duration for left/right spins, in clk cycles (≥1).
- `SETTLE_CYCLES`, default 1000: brake gap after each action (≥1).
- `CNT_W`, default 20: duration counter width. All three durations must be < 2^CNT_W.
- `PWM_DUTY`, default 192: on-count out of 256. Used only with `EXEC_PWM_EN`.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `movement_sel` in 4: command from the search FSM. Encoding:
  - 0001 forward, 0010 right spin, 0100 reverse, 1000 left spin.
  - 0000 no command; any other value is illegal.
- `estop` in 1: synchronous emergency stop, level, highest priority.
- `motor_drive` out 4: [0] L_fwd, [1] L_rev, [2] R_fwd, [3] R_rev.
- `active_cmd` out 4: command being executed; 0000 when none.
- `busy` out 1: high in CAPTURE, RUN and SETTLE.
- `done` out 1: one-cycle pulse when an action completes normally.
- `aborted` out 1: one-cycle pulse when estop cuts an action.
- `cmd_err` out 1: one-cycle pulse on a stable illegal code.

## Operation
- Drive patterns: forward 0101, reverse 1010, right 1001, left 0110. `motor_drive` is never 0011 or 1100 in any state.
- FSM states: IDLE, CAPTURE, RUN, SETTLE. All are registered outputs.
- IDLE → CAPTURE
  - Taken when `movement_sel` ≠ 0, `estop` = 0 and the err-lock is clear.
  - Sampled code is stored in `cap_q`.
- CAPTURE
  - `movement_sel` == `cap_q` and code legal → RUN. Load counter with duration−1; `active_cmd` ← code.
  - Equal but illegal → pulse `cmd_err`, set err-lock, go to IDLE.
  - Code differs → IDLE, no pulse.
- Err-lock clears on the first cycle `movement_sel` ≠ locked value.
- RUN
  - `motor_drive` = pattern; counter decrements each cycle.
  - At 0 → SETTLE; load counter with SETTLE_CYCLES−1.
  - `movement_sel` changes are ignored while in RUN.
- SETTLE
  - `motor_drive` = 0000; counter decrements.
  - At 0 → IDLE with `done` pulsed that cycle; `active_cmd` ← 0.
- Held command re-executes: a code still present after `done` starts a new action. Step-wise motion is intended.
- estop
  - In RUN or CAPTURE: next state SETTLE, `motor_drive` 0 next cycle, `aborted` pulsed (RUN only), no `done`.
  - In SETTLE: settle continues.
  - In IDLE: no capture while high.
- Reset: state IDLE, all outputs 0, counter 0, err-lock clear.

## Timing
- `movement_sel` stable from edge N → CAPTURE at N+1, RUN at N+2. `motor_drive` first nonzero in cycle N+2.
- RUN lasts exactly FWD_CYCLES or TURN_CYCLES cycles. SETTLE lasts exactly SETTLE_CYCLES cycles.
- `done` is high for the single clock that registers IDLE after SETTLE. Earliest next RUN is 2 cycles later.
- estop sampled at edge M → `motor_drive` = 0 from M+1.
- Reset mid-action: outputs go to 0 asynchronously. Resumption requires a fresh capture.

## Configuration
- `EXEC_PWM_EN` defined
  - Free-running 8-bit counter; drive bits are ANDed with (cnt < `PWM_DUTY`).
  - The counter runs continuously and is reset to 0.
  - Durations are still counted in clk cycles, not PWM periods.
- Undefined: `motor_drive` is a steady level; `PWM_DUTY` is ignored.

## Structure
- Package `movement_pkg` holds:
  - The state enum.
  - The command codes (CMD_FWD, CMD_RIGHT, CMD_REV, CMD_LEFT, CMD_NONE).
  - The four drive patterns and the code→pattern/duration function.
- Sub-module `pwm_gen` (8-bit counter plus compare) is instantiated only under `EXEC_PWM_EN`.

## Test plan
- FWD_CYCLES=8, SETTLE=3; hold 0001 from edge 0 → `motor_drive` 0101 for cycles 2–9, 0000 for 10–12, `done` at 13, RUN again from 15.
- 0010 for one cycle then 0000 → CAPTURE then IDLE; `motor_drive` never nonzero, no pulses.
- Hold 0011 → single `cmd_err` pulse; no further pulses until `movement_sel` changes; then 1000 executes 0110 for TURN_CYCLES.
- estop at RUN cycle 4 → `motor_drive` 0 next cycle, `aborted` pulse, SETTLE for 3 cycles, no `done`.
- Deassert `rst_n` mid-RUN → all outputs 0 immediately; after release, IDLE and fresh 2-cycle capture.
- With `EXEC_PWM_EN`, PWM_DUTY=64, forward → drive high in exactly 64 of every 256 RUN cycles.

Source files
------------

// File: rtl/movement_pkg.sv
// Shared types, command codes and drive patterns for the movement executor.
package movement_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_RUN,
    S_SETTLE
  } state_t;

  localparam logic [3:0] CMD_NONE  = 4'b0000;
  localparam logic [3:0] CMD_FWD   = 4'b0001;
  localparam logic [3:0] CMD_RIGHT = 4'b0010;
  localparam logic [3:0] CMD_REV   = 4'b0100;
  localparam logic [3:0] CMD_LEFT  = 4'b1000;

  // Bit order: [0] L_fwd, [1] L_rev, [2] R_fwd, [3] R_rev
  localparam logic [3:0] DRV_OFF   = 4'b0000;
  localparam logic [3:0] DRV_FWD   = 4'b0101;
  localparam logic [3:0] DRV_REV   = 4'b1010;
  localparam logic [3:0] DRV_RIGHT = 4'b1001;
  localparam logic [3:0] DRV_LEFT  = 4'b0110;

  typedef struct packed {
    logic       legal;
    logic       turn;
    logic [3:0] drive;
  } cmd_info_t;

  // turn selects the spin duration instead of the straight-line one
  function automatic cmd_info_t cmd_decode(input logic [3:0] code);
    cmd_info_t r;
    r = '0;
    unique case (1'b1)
      (code == CMD_FWD): begin
        r.legal = 1'b1;
        r.drive = DRV_FWD;
      end
      (code == CMD_REV): begin
        r.legal = 1'b1;
        r.drive = DRV_REV;
      end
      (code == CMD_RIGHT): begin
        r.legal = 1'b1;
        r.turn  = 1'b1;
        r.drive = DRV_RIGHT;
      end
      (code == CMD_LEFT): begin
        r.legal = 1'b1;
        r.turn  = 1'b1;
        r.drive = DRV_LEFT;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/movement_executor_pwm_gen.sv
// Free-running 8-bit PWM counter with duty compare.
// Only instantiated when EXEC_PWM_EN is defined.
module pwm_gen #(
  parameter int DUTY = 192
) (
  input  logic clk,
  input  logic rst_n,
  output logic on
);

  localparam logic [8:0] DUTY_W = 9'(DUTY);

  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_q + 8'd1;
  end

  assign on = ({1'b0, cnt_q} < DUTY_W);

endmodule

// File: rtl/movement_executor.sv
// Timed, bounded two-wheel motor actions from the search FSM command bus.
// Optional feature: define EXEC_PWM_EN to chop the drive with pwm_gen.
module movement_executor
  import movement_pkg::*;
#(
  parameter int FWD_CYCLES    = 50000,
  parameter int TURN_CYCLES   = 25000,
  parameter int SETTLE_CYCLES = 1000,
  parameter int CNT_W         = 20,
  parameter int PWM_DUTY      = 192
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] movement_sel,
  input  logic       estop,
  output logic [3:0] motor_drive,
  output logic [3:0] active_cmd,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       cmd_err
);

  localparam logic [CNT_W-1:0] FWD_LD  = CNT_W'(FWD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LD = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LD  = CNT_W'(SETTLE_CYCLES - 1);

  if (FWD_CYCLES < 1 || TURN_CYCLES < 1 || SETTLE_CYCLES < 1 ||
      PWM_DUTY < 0 || PWM_DUTY > 256) begin : g_bad_cfg
    $error("movement_executor: bad configuration");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cap_q, cap_d;
  logic [3:0]       lockv_q, lockv_d;
  logic             lock_q, lock_d;
  logic             abt_q, abt_d;
  logic [3:0]       drive_q, drive_d;
  logic [3:0]       active_d;
  logic             busy_d, done_d, aborted_d, err_d;
  cmd_info_t        info;

  assign info = cmd_decode(cap_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    lock_d    = lock_q;
    lockv_d   = lockv_q;
    abt_d     = abt_q;
    drive_d   = drive_q;
    active_d  = active_cmd;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    err_d     = 1'b0;

    if (lock_q && movement_sel != lockv_q) lock_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (movement_sel != CMD_NONE && !estop && !lock_q) begin
          state_d = S_CAPTURE;
          cap_d   = movement_sel;
        end
      end
      S_CAPTURE: begin
        if (estop) begin
          state_d = S_SETTLE;
          cnt_d   = SET_LD;
          drive_d = DRV_OFF;
          abt_d   = 1'b1;
        end else if (movement_sel != cap_q) begin
          state_d = S_IDLE;
        end else if (!info.legal) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          lock_d  = 1'b1;
          lockv_d = cap_q;
        end else begin
          state_d  = S_RUN;
          cnt_d    = info.turn ? TURN_LD : FWD_LD;
          active_d = cap_q;
          drive_d  = info.drive;
        end
      end
      S_RUN: begin
        if (estop) begin
          state_d   = S_SETTLE;
          cnt_d     = SET_LD;
          drive_d   = DRV_OFF;
          abt_d     = 1'b1;
          aborted_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_SETTLE;
          cnt_d   = SET_LD;
          drive_d = DRV_OFF;
          abt_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SETTLE: begin
        // an estop-cut action still settles fully but never reports done
        if (cnt_q == '0) begin
          state_d  = S_IDLE;
          active_d = CMD_NONE;
          done_d   = !abt_q;
          abt_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cap_q      <= CMD_NONE;
      lock_q     <= 1'b0;
      lockv_q    <= CMD_NONE;
      abt_q      <= 1'b0;
      drive_q    <= DRV_OFF;
      active_cmd <= CMD_NONE;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      lock_q     <= lock_d;
      lockv_q    <= lockv_d;
      abt_q      <= abt_d;
      drive_q    <= drive_d;
      active_cmd <= active_d;
      busy       <= busy_d;
      done       <= done_d;
      aborted    <= aborted_d;
      cmd_err    <= err_d;
    end
  end

`ifdef EXEC_PWM_EN
  logic pwm_on;

  pwm_gen #(
    .DUTY(PWM_DUTY)
  ) u_pwm (
    .clk  (clk),
    .rst_n(rst_n),
    .on   (pwm_on)
  );

  assign motor_drive = drive_q & {4{pwm_on}};
`else
  assign motor_drive = drive_q;
`endif

endmodule
